tlul_host_arbiter: RTL and testbench
====================================

Name: tlul_host_arbiter

Overview:
- Round-robin arbiter that shares one TL-UL A/D channel pair between NumHosts TL-UL requesters.
- Sits directly upstream of the TL-UL-to-AXI4 bridge, whose A channel accepts one request at a time.
- Tags each forwarded request with the host index in the upper source bits. Routes each D response back to its host by that index.
- Caps in-flight requests at MaxOutstanding.

Parameters:
- NumHosts, 4, number of upstream requesters (2..8).
- HostIdxW, $clog2(NumHosts), width of the host index tag.
- AddrWidth, 32, address width.
- DataWidth, 64, data width.
- SourceWidth, 6, per-host source width; downstream source width is SourceWidth+HostIdxW.
- MaxSize, 6, size field width.
- MaxOutstanding, 1, maximum A-accepted-but-D-not-yet-accepted requests (1..15).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- h_a_valid  in  NumHosts  per-host A valid
- h_a_ready  out  NumHosts  per-host A ready
- h_a_address  in  NumHosts*AddrWidth  packed per-host address, host i at [i*AddrWidth +: AddrWidth]
- h_a_data  in  NumHosts*DataWidth  packed per-host write data
- h_a_mask  in  NumHosts*DataWidth/8  packed per-host byte mask
- h_a_opcode  in  NumHosts*3  packed per-host opcode
- h_a_size  in  NumHosts*MaxSize  packed per-host size
- h_a_source  in  NumHosts*SourceWidth  packed per-host source
- h_d_valid  out  NumHosts  per-host D valid
- h_d_ready  in  NumHosts  per-host D ready
- h_d_data  out  DataWidth  D data, broadcast to all hosts
- h_d_opcode  out  3  D opcode, broadcast
- h_d_error  out  2  D error, broadcast
- h_d_source  out  SourceWidth  D source with host tag stripped, broadcast
- m_a_valid  out  1  downstream A valid
- m_a_ready  in  1  downstream A ready
- m_a_address  out  AddrWidth  downstream address
- m_a_data  out  DataWidth  downstream data
- m_a_mask  out  DataWidth/8  downstream mask
- m_a_opcode  out  3  downstream opcode
- m_a_size  out  MaxSize  downstream size
- m_a_source  out  SourceWidth+HostIdxW  {grant index, host source}
- m_d_valid  in  1  downstream D valid
- m_d_ready  out  1  downstream D ready
- m_d_data  in  DataWidth  downstream D data
- m_d_opcode  in  3  downstream D opcode
- m_d_error  in  2  downstream D error
- m_d_source  in  SourceWidth+HostIdxW  downstream D source

Behaviour:
- Reset values:
  - FSM=IDLE, grant index=0, priority pointer=0, outstanding count=0.
  - m_a_valid=0, all h_a_ready=0, all h_d_valid=0.
- States:
  - IDLE (no grant):
    - If any h_a_valid is set and outstanding < MaxOutstanding, select the first valid host at or after the priority pointer, wrapping modulo NumHosts.
    - Register that host as the grant index and go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT:
    - m_a_* are driven combinationally from the granted host's slice.
    - m_a_valid = h_a_valid[grant]; h_a_ready[grant] = m_a_ready; all other h_a_ready = 0.
    - On handshake (m_a_valid & m_a_ready): increment the outstanding count, set pointer = (grant+1) mod NumHosts, return to IDLE.
    - The grant is held until the handshake, even if the host deasserts valid (a protocol violation) or a higher-priority host asserts valid.
- Latency:
  - A host request seen in cycle N gives m_a_valid in cycle N+1.
  - Minimum of 2 cycles per accepted request (the IDLE→GRANT cycle is not bypassed).
- D routing (combinational):
  - idx = m_d_source[SourceWidth +: HostIdxW].
  - h_d_valid[idx] = m_d_valid; m_d_ready = h_d_ready[idx]; h_d_source = m_d_source[SourceWidth-1:0].
  - If idx >= NumHosts: assert no h_d_valid, m_d_ready=1 (response is dropped), and do not decrement the count.
- Outstanding counter:
  - Width $clog2(MaxOutstanding+1).
  - A D handshake with a valid idx decrements it.
  - A and D handshakes in the same cycle leave it unchanged.
  - A D handshake at count 0 saturates at 0.
- Full condition: at count == MaxOutstanding, no new grant is issued. A grant already in GRANT state cannot exist at that point, because the count is checked at grant time.
- Reset mid-operation: all state returns to the reset values immediately; in-flight bookkeeping is discarded.

Test Plan:
- Single host: host0 requests, source 0x05, address 0x1000, m_a_ready=1.
  - m_a_valid in cycle 1 with m_a_source=0x05, address 0x1000; h_a_ready[0]=1 in that cycle.
  - m_d_source=0x05 returns → h_d_valid[0]=1, h_d_source=0x05.
- Round-robin: hosts 0–3 all hold valid, MaxOutstanding=15, D responses immediate → grant order 0,1,2,3,0; each grant occupies 2 cycles.
- Outstanding cap: MaxOutstanding=1, no D response → second request is held in IDLE with m_a_valid=0; D handshake → grant issued on the next cycle.
- Backpressure: m_a_ready=0 for 5 cycles while host2 is granted and host1 asserts valid → grant stays on 2, m_a_* stable, h_a_ready=0 everywhere; after the handshake the pointer is 3 and host1 is granted next.
- D stall plus simultaneous A/D: h_d_ready[1]=0 holds m_d_ready=0. An A and a D handshake in the same cycle leave the count unchanged. An out-of-range tag (NumHosts=3, idx=3) is dropped with m_d_ready=1 and the count unchanged.
- Reset asserted during GRANT → m_a_valid=0 and all h_*_valid/ready=0 asynchronously; the first request after release is arbitrated from pointer 0.

Source files
------------

// File: rtl/tlul_host_arbiter.sv
// Round-robin arbiter sharing one TL-UL A/D channel pair between NumHosts requesters.
//
// Each A request is granted in two steps. In the IDLE cycle a host is picked, and in
// the following GRANT cycle(s) that host is forwarded downstream. The host index is
// prepended to the source field so that D responses can be steered back to their host.
// The number of requests that have been accepted on A but not yet completed on D is
// capped at MaxOutstanding.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   h_a_*                  per-host A channel, packed with host i at slice i
//   h_d_*                  per-host D valid/ready; D payload is broadcast to all hosts
//   m_a_*                  downstream A channel; m_a_source = {grant index, host source}
//   m_d_*                  downstream D channel; host index taken from m_d_source upper bits
module tlul_host_arbiter #(
  parameter int unsigned NumHosts       = 4,
  parameter int unsigned HostIdxW       = $clog2(NumHosts),
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned SourceWidth    = 6,
  parameter int unsigned MaxSize        = 6,
  parameter int unsigned MaxOutstanding = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,

  input  logic [NumHosts-1:0]               h_a_valid,
  output logic [NumHosts-1:0]               h_a_ready,
  input  logic [NumHosts*AddrWidth-1:0]     h_a_address,
  input  logic [NumHosts*DataWidth-1:0]     h_a_data,
  input  logic [NumHosts*DataWidth/8-1:0]   h_a_mask,
  input  logic [NumHosts*3-1:0]             h_a_opcode,
  input  logic [NumHosts*MaxSize-1:0]       h_a_size,
  input  logic [NumHosts*SourceWidth-1:0]   h_a_source,

  output logic [NumHosts-1:0]               h_d_valid,
  input  logic [NumHosts-1:0]               h_d_ready,
  output logic [DataWidth-1:0]              h_d_data,
  output logic [2:0]                        h_d_opcode,
  output logic [1:0]                        h_d_error,
  output logic [SourceWidth-1:0]            h_d_source,

  output logic                              m_a_valid,
  input  logic                              m_a_ready,
  output logic [AddrWidth-1:0]              m_a_address,
  output logic [DataWidth-1:0]              m_a_data,
  output logic [DataWidth/8-1:0]            m_a_mask,
  output logic [2:0]                        m_a_opcode,
  output logic [MaxSize-1:0]                m_a_size,
  output logic [SourceWidth+HostIdxW-1:0]   m_a_source,

  input  logic                              m_d_valid,
  output logic                              m_d_ready,
  input  logic [DataWidth-1:0]              m_d_data,
  input  logic [2:0]                        m_d_opcode,
  input  logic [1:0]                        m_d_error,
  input  logic [SourceWidth+HostIdxW-1:0]   m_d_source
);

  localparam int unsigned MaskWidth = DataWidth / 8;
  localparam int unsigned CntW      = $clog2(MaxOutstanding + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q, state_d;
  logic [HostIdxW-1:0] grant_q, grant_d;
  logic [HostIdxW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  // Per-host views of the packed A payload buses.
  logic [AddrWidth-1:0]   a_addr [NumHosts];
  logic [DataWidth-1:0]   a_data [NumHosts];
  logic [MaskWidth-1:0]   a_mask [NumHosts];
  logic [2:0]             a_op   [NumHosts];
  logic [MaxSize-1:0]     a_size [NumHosts];
  logic [SourceWidth-1:0] a_src  [NumHosts];

  for (genvar i = 0; i < NumHosts; i++) begin : g_unpack
    assign a_addr[i] = h_a_address[i*AddrWidth +: AddrWidth];
    assign a_data[i] = h_a_data[i*DataWidth +: DataWidth];
    assign a_mask[i] = h_a_mask[i*MaskWidth +: MaskWidth];
    assign a_op[i]   = h_a_opcode[i*3 +: 3];
    assign a_size[i] = h_a_size[i*MaxSize +: MaxSize];
    assign a_src[i]  = h_a_source[i*SourceWidth +: SourceWidth];
  end

  // First requesting host at or after the priority pointer, wrapping around.
  logic [HostIdxW-1:0] rr_sel;
  logic                rr_found;

  always_comb begin
    int unsigned         cand;
    logic [HostIdxW-1:0] cand_idx;
    rr_sel   = ptr_q;
    rr_found = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NumHosts; k++) begin
      cand     = (32'(ptr_q) + k) % NumHosts;
      cand_idx = HostIdxW'(cand);
      if (!rr_found && h_a_valid[cand_idx]) begin
        rr_found = 1'b1;
        rr_sel   = cand_idx;
      end
    end
  end

  logic can_issue;
  assign can_issue = (cnt_q < CntW'(MaxOutstanding));

  // A channel: only the granted host is connected, and only while in GRANT.
  always_comb begin
    m_a_valid = 1'b0;
    h_a_ready = '0;
    if (state_q == StGrant) begin
      m_a_valid          = h_a_valid[grant_q];
      h_a_ready[grant_q] = m_a_ready;
    end
  end

  assign m_a_address = a_addr[grant_q];
  assign m_a_data    = a_data[grant_q];
  assign m_a_mask    = a_mask[grant_q];
  assign m_a_opcode  = a_op[grant_q];
  assign m_a_size    = a_size[grant_q];
  assign m_a_source  = {grant_q, a_src[grant_q]};

  // D channel: steer by the host tag; responses with an unknown tag are sunk.
  logic [HostIdxW-1:0] d_idx;
  logic                d_idx_ok;

  assign d_idx      = m_d_source[SourceWidth +: HostIdxW];
  assign d_idx_ok   = (32'(d_idx) < NumHosts);
  assign h_d_data   = m_d_data;
  assign h_d_opcode = m_d_opcode;
  assign h_d_error  = m_d_error;
  assign h_d_source = m_d_source[SourceWidth-1:0];

  always_comb begin
    h_d_valid = '0;
    m_d_ready = 1'b1;
    if (d_idx_ok) begin
      h_d_valid[d_idx] = m_d_valid;
      m_d_ready        = h_d_ready[d_idx];
    end
  end

  logic a_hs, d_hs;
  assign a_hs = (state_q == StGrant) && m_a_valid && m_a_ready;
  // Dropped responses never counted as outstanding, so they must not decrement.
  assign d_hs = m_d_valid && m_d_ready && d_idx_ok;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (rr_found && can_issue) begin
          grant_d = rr_sel;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // The grant is held until the handshake, whatever the other hosts do.
        if (a_hs) begin
          ptr_d   = (32'(grant_q) == NumHosts - 1) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (a_hs && !d_hs) begin
      cnt_d = cnt_q + 1'b1;
    end else if (d_hs && !a_hs && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Scoreboard bench for tlul_host_arbiter with three hosts (so host tag 3 is out of range)
// and a cap of two outstanding requests.
`timescale 1ns/1ps
module tb_tlul_host_arbiter;
  localparam int NH = 3;
  localparam int IW = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int SW = 6;
  localparam int SZ = 6;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NH-1:0]    h_a_valid, h_a_ready, h_d_valid, h_d_ready;
  logic [NH*AW-1:0] h_a_address;
  logic [NH*DW-1:0] h_a_data;
  logic [NH*MW-1:0] h_a_mask;
  logic [NH*3-1:0]  h_a_opcode;
  logic [NH*SZ-1:0] h_a_size;
  logic [NH*SW-1:0] h_a_source;
  logic [DW-1:0]    h_d_data;
  logic [2:0]       h_d_opcode;
  logic [1:0]       h_d_error;
  logic [SW-1:0]    h_d_source;
  logic             m_a_valid, m_a_ready;
  logic [AW-1:0]    m_a_address;
  logic [DW-1:0]    m_a_data;
  logic [MW-1:0]    m_a_mask;
  logic [2:0]       m_a_opcode;
  logic [SZ-1:0]    m_a_size;
  logic [SW+IW-1:0] m_a_source;
  logic             m_d_valid, m_d_ready;
  logic [DW-1:0]    m_d_data;
  logic [2:0]       m_d_opcode;
  logic [1:0]       m_d_error;
  logic [SW+IW-1:0] m_d_source;

  tlul_host_arbiter #(
    .NumHosts(NH), .AddrWidth(AW), .DataWidth(DW), .SourceWidth(SW),
    .MaxSize(SZ), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .h_a_valid(h_a_valid), .h_a_ready(h_a_ready), .h_a_address(h_a_address),
    .h_a_data(h_a_data), .h_a_mask(h_a_mask), .h_a_opcode(h_a_opcode),
    .h_a_size(h_a_size), .h_a_source(h_a_source),
    .h_d_valid(h_d_valid), .h_d_ready(h_d_ready), .h_d_data(h_d_data),
    .h_d_opcode(h_d_opcode), .h_d_error(h_d_error), .h_d_source(h_d_source),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_address(m_a_address),
    .m_a_data(m_a_data), .m_a_mask(m_a_mask), .m_a_opcode(m_a_opcode),
    .m_a_size(m_a_size), .m_a_source(m_a_source),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_data(m_d_data),
    .m_d_opcode(m_d_opcode), .m_d_error(m_d_error), .m_d_source(m_d_source)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic [2:0]    op;
    logic [SZ-1:0] size;
    logic [SW-1:0] src;
  } req_t;

  typedef struct packed {
    logic          good;
    logic [IW-1:0] host;
    logic [SW-1:0] src;
    logic [DW-1:0] data;
    logic [2:0]    op;
    logic [1:0]    err;
  } rsp_t;

  req_t             host_q[NH][$];
  req_t             exp_a[NH][$];
  rsp_t             exp_d[$];
  logic [SW+IW-1:0] resp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  int req_pct, resp_pct, bad_pct, rdy_pct, dready_pct;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input string what);
    n_chk++;
    $display("FAIL %s: got %s (t=%0t)", name, what, $time);
  endtask

  // ---------------- reference model + monitor ----------------
  // Abstract view: either no grant, or one host owns the channel. A decision is taken in
  // any idle cycle with a requester and fewer than MO requests in flight; the winner is the
  // first requester counting up from the pointer, and it shows on m_a the next cycle.
  logic          mdl_busy;
  int            mdl_win, mdl_ptr, mdl_cnt;
  logic [NH-1:0] mon_exp_rdy, mon_exp_dv;
  logic          mon_a_take, mon_d_take, mon_dec, mon_found;
  req_t          mon_e;
  rsp_t          mon_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_busy = 1'b0;
      mdl_win  = 0;
      mdl_ptr  = 0;
      mdl_cnt  = 0;
    end else begin
      mon_exp_rdy = '0;
      if (mdl_busy) mon_exp_rdy[mdl_win] = m_a_ready;
      check("a_valid", 64'(m_a_valid), 64'(mdl_busy));
      check("a_ready", 64'(h_a_ready), 64'(mon_exp_rdy));
      if (mdl_busy) begin
        if (exp_a[mdl_win].size() == 0) begin
          fail_now("a_order", "grant with no queued request");
        end else begin
          mon_e = exp_a[mdl_win][0];
          check("a_address", 64'(m_a_address), 64'(mon_e.addr));
          check("a_data", m_a_data, mon_e.data);
          check("a_mask", 64'(m_a_mask), 64'(mon_e.mask));
          check("a_opcode", 64'(m_a_opcode), 64'(mon_e.op));
          check("a_size", 64'(m_a_size), 64'(mon_e.size));
          check("a_source", 64'(m_a_source), 64'(mdl_win * (1 << SW) + int'(mon_e.src)));
        end
      end

      mon_d_take = 1'b0;
      mon_dec    = 1'b0;
      if (m_d_valid) begin
        if (exp_d.size() == 0) begin
          fail_now("d_order", "response with no expectation");
        end else begin
          mon_r = exp_d[0];
          if (mon_r.good) begin
            mon_exp_dv = '0;
            mon_exp_dv[mon_r.host] = 1'b1;
            check("d_valid", 64'(h_d_valid), 64'(mon_exp_dv));
            check("d_ready", 64'(m_d_ready), 64'(h_d_ready[mon_r.host]));
            check("d_data", h_d_data, mon_r.data);
            check("d_opcode", 64'(h_d_opcode), 64'(mon_r.op));
            check("d_error", 64'(h_d_error), 64'(mon_r.err));
            check("d_source", 64'(h_d_source), 64'(mon_r.src));
            mon_d_take = h_d_ready[mon_r.host];
            mon_dec    = mon_d_take;
          end else begin
            check("d_drop_valid", 64'(h_d_valid), 64'(0));
            check("d_drop_ready", 64'(m_d_ready), 64'(1));
            mon_d_take = 1'b1;
          end
          if (mon_d_take) void'(exp_d.pop_front());
        end
      end else begin
        check("d_idle", 64'(h_d_valid), 64'(0));
      end

      mon_a_take = mdl_busy && m_a_ready;
      if (mon_a_take) begin
        void'(exp_a[mdl_win].pop_front());
        mdl_busy = 1'b0;
        mdl_ptr  = (mdl_win + 1) % NH;
      end else if (!mdl_busy && h_a_valid != '0 && mdl_cnt < MO) begin
        mon_found = 1'b0;
        for (int k = 0; k < NH; k++) begin
          if (!mon_found && h_a_valid[(mdl_ptr + k) % NH]) begin
            mon_found = 1'b1;
            mdl_win   = (mdl_ptr + k) % NH;
          end
        end
        mdl_busy = 1'b1;
      end
      mdl_cnt = mdl_cnt + (mon_a_take ? 1 : 0) - (mon_dec ? 1 : 0);
      if (mdl_cnt < 0) mdl_cnt = 0;
    end
  end

  // ---------------- stimulus ----------------
  function automatic req_t rand_req();
    req_t r;
    r.addr = $urandom;
    r.data = {$urandom, $urandom};
    r.mask = MW'($urandom);
    r.op   = 3'($urandom);
    r.size = SZ'($urandom);
    r.src  = SW'($urandom);
    return r;
  endfunction

  task automatic add_req(input int i, input req_t r);
    host_q[i].push_back(r);
    exp_a[i].push_back(r);
  endtask

  task automatic drive_hosts();
    req_t r;
    for (int i = 0; i < NH; i++) begin
      if (host_q[i].size() > 0) r = host_q[i][0];
      else r = rand_req();
      h_a_valid[i]             = (host_q[i].size() > 0);
      h_a_address[i*AW +: AW]  = r.addr;
      h_a_data[i*DW +: DW]     = r.data;
      h_a_mask[i*MW +: MW]     = r.mask;
      h_a_opcode[i*3 +: 3]     = r.op;
      h_a_size[i*SZ +: SZ]     = r.size;
      h_a_source[i*SW +: SW]   = r.src;
    end
  endtask

  task automatic present(input logic [SW+IW-1:0] src);
    rsp_t r;
    m_d_valid  = 1'b1;
    m_d_source = src;
    m_d_data   = {$urandom, $urandom};
    m_d_opcode = 3'($urandom);
    m_d_error  = 2'($urandom);
    r.good = (int'(src[SW +: IW]) < NH);
    r.host = src[SW +: IW];
    r.src  = src[SW-1:0];
    r.data = m_d_data;
    r.op   = m_d_opcode;
    r.err  = m_d_error;
    exp_d.push_back(r);
  endtask

  // One clock of stimulus: observe handshakes mid-cycle, then update just after the edge.
  task automatic cycle();
    logic [NH-1:0]    hs;
    logic             ahs, dhs;
    logic [SW+IW-1:0] asrc;
    req_t             dummy;
    @(negedge clk);
    hs   = h_a_valid & h_a_ready;
    ahs  = m_a_valid & m_a_ready;
    asrc = m_a_source;
    dhs  = m_d_valid & m_d_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NH; i++) if (hs[i]) dummy = host_q[i].pop_front();
    if (ahs) resp_q.push_back(asrc);
    if (dhs) m_d_valid = 1'b0;
    for (int i = 0; i < NH; i++) begin
      if ($urandom_range(99) < req_pct && host_q[i].size() < 4) add_req(i, rand_req());
    end
    if (!m_d_valid) begin
      if (resp_q.size() > 0 && $urandom_range(99) < resp_pct) begin
        present(resp_q.pop_front());
      end else if ($urandom_range(99) < bad_pct) begin
        present({2'd3, SW'($urandom)});
      end else if (resp_q.size() == 0 && $urandom_range(99) < bad_pct) begin
        present({IW'($urandom_range(NH - 1)), SW'($urandom)});
      end
    end
    m_a_ready = ($urandom_range(99) < rdy_pct);
    for (int i = 0; i < NH; i++) h_d_ready[i] = ($urandom_range(99) < dready_pct);
    drive_hosts();
  endtask

  task automatic drain(input string name);
    int left;
    req_pct = 0; bad_pct = 0; resp_pct = 100; rdy_pct = 100; dready_pct = 100;
    for (int c = 0; c < 400; c++) begin
      left = int'(resp_q.size()) + (m_d_valid ? 1 : 0);
      for (int i = 0; i < NH; i++) left += int'(host_q[i].size());
      if (left == 0) break;
      cycle();
    end
    left = int'(resp_q.size()) + (m_d_valid ? 1 : 0);
    for (int i = 0; i < NH; i++) left += int'(exp_a[i].size());
    check(name, 64'(left), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: still running at %0t, expected finish long before", $time);
    $fatal(1);
  end

  initial begin
    req_t r;
    logic seen;
    h_a_valid = '0; h_a_address = '0; h_a_data = '0; h_a_mask = '0;
    h_a_opcode = '0; h_a_size = '0; h_a_source = '0; h_d_ready = '0;
    m_a_ready = 1'b0; m_d_valid = 1'b0; m_d_data = '0; m_d_opcode = '0;
    m_d_error = '0; m_d_source = '0;
    req_pct = 0; resp_pct = 100; bad_pct = 0; rdy_pct = 100; dready_pct = 100;

    #1 rst_n = 1'b0;
    #1;
    check("reset_a_valid", 64'(m_a_valid), 64'(0));
    check("reset_a_ready", 64'(h_a_ready), 64'(0));
    check("reset_d_valid", 64'(h_d_valid), 64'(0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single host, source 0x05, address 0x1000.
    m_a_ready = 1'b1; h_d_ready = '1;
    r = rand_req(); r.addr = 32'h1000; r.src = 6'h05;
    add_req(0, r);
    drive_hosts();
    repeat (10) cycle();

    // Round robin with every host loaded.
    for (int n = 0; n < 4; n++) for (int i = 0; i < NH; i++) add_req(i, rand_req());
    drive_hosts();
    repeat (60) cycle();

    // Outstanding cap: no responses for a while, then release them.
    req_pct = 40; resp_pct = 0;
    repeat (30) cycle();
    resp_pct = 100;
    repeat (20) cycle();

    // Random traffic with A/D backpressure, dropped tags and spurious responses.
    req_pct = 30; resp_pct = 50; bad_pct = 5; rdy_pct = 60; dready_pct = 70;
    repeat (1500) cycle();
    drain("drain_random");

    // Reset while a grant is waiting on m_a_ready.
    for (int i = 0; i < NH; i++) add_req(i, rand_req());
    req_pct = 0; rdy_pct = 0; resp_pct = 0;
    drive_hosts();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle();
      #1 seen = m_a_valid;
    end
    check("pre_reset_grant", 64'(seen), 64'(1));
    m_d_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_a_valid", 64'(m_a_valid), 64'(0));
    check("midrst_a_ready", 64'(h_a_ready), 64'(0));
    check("midrst_d_valid", 64'(h_d_valid), 64'(0));
    for (int i = 0; i < NH; i++) begin
      host_q[i].delete();
      exp_a[i].delete();
    end
    exp_d.delete();
    resp_q.delete();
    drive_hosts();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // After reset the pointer is back at 0, so host 1 wins over host 2.
    add_req(2, rand_req());
    add_req(1, rand_req());
    drive_hosts();
    rdy_pct = 100; resp_pct = 100;
    repeat (10) cycle();
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
